// File: rtl/div_seq_ctrl.sv
// Restoring unsigned divider sequencer: one quotient bit per granted cycle on a shared
// WIDTH-bit adder, with a start/done handshake toward the control unit.
module div_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_start,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic             out_busy,
   output logic             out_done,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_div_zero,
   output logic             out_add_req,
   input  logic             in_add_gnt,
   output logic [WIDTH-1:0] out_add_a,
   output logic [WIDTH-1:0] out_add_b,
   output logic             out_add_cin,
   input  logic [WIDTH-1:0] in_add_sum,
   input  logic             in_add_cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] m_r;
   logic [CW-1:0]    cnt_r;

   logic             shift_s;
   logic [WIDTH-1:0] a_shift_s;
   logic             ok_s;
   logic [WIDTH-1:0] a_next_s;
   logic [WIDTH-1:0] q_next_s;
   logic             last_s;

   // Trial subtract: the bit shifted out of A keeps As - M exact on a WIDTH-bit adder
   always_comb begin
      {shift_s, a_shift_s} = {a_r, q_r[WIDTH-1]};
      ok_s     = shift_s | in_add_cout;
      a_next_s = ok_s ? in_add_sum : a_shift_s;
      q_next_s = {q_r[WIDTH-2:0], ok_s};
      last_s   = (cnt_r == CW'(WIDTH - 1));
      if (state_r == ST_RUN) begin
         out_add_a   = a_shift_s;
         out_add_b   = ~m_r;
         out_add_cin = 1'b1;
      end else begin
         out_add_a   = {WIDTH{1'b0}};
         out_add_b   = {WIDTH{1'b0}};
         out_add_cin = 1'b0;
      end
   end

   // Sequencer state, datapath registers and registered handshake outputs
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         state_r       <= ST_IDLE;
         a_r           <= {WIDTH{1'b0}};
         q_r           <= {WIDTH{1'b0}};
         m_r           <= {WIDTH{1'b0}};
         cnt_r         <= {CW{1'b0}};
         out_busy      <= 1'b0;
         out_done      <= 1'b0;
         out_quotient  <= {WIDTH{1'b0}};
         out_remainder <= {WIDTH{1'b0}};
         out_div_zero  <= 1'b0;
         out_add_req   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               out_done <= 1'b0;
               if (in_start) begin
                  a_r           <= {WIDTH{1'b0}};
                  q_r           <= in_dividend;
                  m_r           <= in_divisor;
                  cnt_r         <= {CW{1'b0}};
                  out_div_zero  <= (in_divisor == {WIDTH{1'b0}});
                  out_quotient  <= {WIDTH{1'b0}};
                  out_remainder <= {WIDTH{1'b0}};
                  out_busy      <= 1'b1;
                  out_add_req   <= 1'b1;
                  state_r       <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Without a grant everything holds and the request stays up
               if (in_add_gnt) begin
                  a_r   <= a_next_s;
                  q_r   <= q_next_s;
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  if (last_s) begin
                     out_quotient  <= q_next_s;
                     out_remainder <= a_next_s;
                     out_add_req   <= 1'b0;
                     out_done      <= 1'b1;
                     state_r       <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               out_done <= 1'b0;
               out_busy <= 1'b0;
               state_r  <= ST_IDLE;
            end
            default: begin
               out_done    <= 1'b0;
               out_busy    <= 1'b0;
               out_add_req <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomised scoreboard bench for div_seq_ctrl: expected results and done cycle are
// queued at each start and popped by a monitor whenever done pulses.
module tb_div_seq_ctrl;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;
   logic         add_req;
   logic         add_gnt;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic         add_cin;
   logic [W-1:0] add_sum;
   logic         add_cout;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int unsigned  cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc;
   int          n_cmp;
   int          n_err;
   int          n_issued;
   int          n_done;

   div_seq_ctrl #(.WIDTH(W)) dut (
      .in_clk       (clk),
      .in_rst_n     (rst_n),
      .in_start     (start),
      .in_dividend  (dividend),
      .in_divisor   (divisor),
      .out_busy     (busy),
      .out_done     (done),
      .out_quotient (quotient),
      .out_remainder(remainder),
      .out_div_zero (div_zero),
      .out_add_req  (add_req),
      .in_add_gnt   (add_gnt),
      .out_add_a    (add_a),
      .out_add_b    (add_b),
      .out_add_cin  (add_cin),
      .in_add_sum   (add_sum),
      .in_add_cout  (add_cout)
   );

   // Shared adder as seen from the divider
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding operation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            check("done_cycle", cyc, e.cyc);
            check("busy_in_done", {31'd0, busy}, 32'd1);
            check("req_in_done", {31'd0, add_req}, 32'd0);
         end
      end
   end

   // Reference: plain unsigned division, with the restoring algorithm's divide-by-zero result
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned c);
      exp_t e;
      e.dz  = (b == 32'd0);
      e.q   = e.dz ? 32'hFFFF_FFFF : a / b;
      e.r   = e.dz ? a : a % b;
      e.cyc = c;
      return e;
   endfunction

   // Issue one divide from a negedge in IDLE; stalls are nstall grant-low cycles from
   // iteration stall_at; abort_at >= 0 pulls reset at that RUN cycle instead of finishing.
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int nstall,
                         input int stall_at, input int abort_at);
      exp_t         e;
      logic [W-1:0] a_before;
      logic         stalled;
      e = model(a, b, cyc + W + 1 + nstall);
      sb.push_back(e);
      n_issued++;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      add_gnt  = 1'b1;
      @(negedge clk);
      check("start_clears_q", quotient, 32'd0);
      check("start_clears_r", remainder, 32'd0);
      check("busy_in_run", {31'd0, busy}, 32'd1);
      check("req_in_run", {31'd0, add_req}, 32'd1);
      for (int i = 0; i < W + nstall; i++) begin
         if (i == abort_at) begin
            rst_n = 1'b0;
            sb.delete();
            n_issued--;
            @(negedge clk);
            rst_n = 1'b1;
            start = 1'b0;
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_req", {31'd0, add_req}, 32'd0);
            check("abort_q", quotient, 32'd0);
            check("abort_r", remainder, 32'd0);
            check("abort_dz", {31'd0, div_zero}, 32'd0);
            check("abort_add_a", add_a, 32'd0);
            return;
         end
         stalled  = (i >= stall_at) && (i < stall_at + nstall);
         add_gnt  = !stalled;
         a_before = add_a;
         start    = $urandom_range(0, 1) == 1;
         dividend = $urandom;
         divisor  = $urandom;
         @(negedge clk);
         if (stalled) begin
            check("stall_freeze", add_a, a_before);
            check("stall_req", {31'd0, add_req}, 32'd1);
         end
      end
      // Done cycle: a start here must be ignored
      start    = 1'b1;
      dividend = $urandom;
      divisor  = $urandom;
      add_gnt  = $urandom_range(0, 1) == 1;
      @(negedge clk);
      start = 1'b0;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("hold_q", quotient, e.q);
      check("hold_r", remainder, e.r);
   endtask

   initial begin
      cyc      = 0;
      n_cmp    = 0;
      n_err    = 0;
      n_issued = 0;
      n_done   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = 32'd0;
      divisor  = 32'd0;
      add_gnt  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_q", quotient, 32'd0);
      check("rst_r", remainder, 32'd0);
      check("rst_dz", {31'd0, div_zero}, 32'd0);
      check("rst_req", {31'd0, add_req}, 32'd0);
      check("rst_add_b", add_b, 32'd0);
      check("rst_cin", {31'd0, add_cin}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_div(32'd100, 32'd7, 0, 0, -1);
      do_div(32'hFFFF_FFFF, 32'd1, 0, 0, -1);
      do_div(32'd5, 32'd9, 0, 0, -1);
      do_div(32'd55, 32'd0, 0, 0, -1);
      do_div(32'd1000, 32'd3, 5, 10, -1);
      do_div(32'd123456, 32'd789, 0, 0, 10);
      do_div(32'd9, 32'd2, 0, 0, -1);

      for (int k = 0; k < 24; k++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         int           mode;
         a    = $urandom;
         mode = $urandom_range(0, 5);
         b    = (mode == 0) ? 32'd0 : (mode < 3) ? 32'($urandom_range(1, 15)) : 32'($urandom);
         if (mode == 5) a = a >> $urandom_range(0, 31);
         do_div(a, b, $urandom_range(0, 3), $urandom_range(0, W - 1), -1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("all_done_seen", 32'(n_done), 32'(n_issued));
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
